// File: rtl/symbol_draw_arbiter.sv
// Round-robin arbiter sharing one symbol-drawing engine and the VGA plot port between four
// requesters, with a watchdog that forces completion if the engine never finishes.
module symbol_draw_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned TIMEOUT = 127
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [8*NUM_REQ-1:0]   req_x,
  input  logic [7*NUM_REQ-1:0]   req_y,
  input  logic [2*NUM_REQ-1:0]   req_sym,
  input  logic [3*NUM_REQ-1:0]   req_col,
  output logic [NUM_REQ-1:0]     ack,
  output logic [NUM_REQ-1:0]     done,
  output logic [NUM_REQ-1:0]     grant,
  output logic                   eng_start,
  output logic [7:0]             eng_x,
  output logic [6:0]             eng_y,
  output logic [1:0]             eng_sym,
  output logic [2:0]             vga_colour,
  input  logic                   eng_plot,
  input  logic                   eng_done,
  output logic                   vga_plot,
  output logic                   err
);

  typedef enum logic [2:0] {StIdle, StGrant, StStart, StDraw, StDone} state_e;

  localparam logic [7:0] WdLast = 8'(TIMEOUT - 1);

  state_e     state_q, state_d;
  logic [3:0] ack_q, ack_d, done_q, done_d, grant_q, grant_d;
  logic       eng_start_q, eng_start_d, err_q, err_d;
  logic [7:0] x_q, x_d;
  logic [6:0] y_q, y_d;
  logic [1:0] sym_q, sym_d;
  logic [2:0] col_q, col_d;
  logic [1:0] last_q, last_d, id_q, id_d;
  logic [7:0] wd_q, wd_d;

  logic       found;
  logic [1:0] win, cand;

  // Scan last+1 .. last+4 (mod 4); the 2-bit add provides the wrap.
  always_comb begin
    found = 1'b0;
    win   = last_q;
    cand  = '0;
    for (int k = 1; k <= 4; k++) begin
      cand = last_q + 2'(k);
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ack_d       = '0;
    done_d      = '0;
    eng_start_d = 1'b0;
    grant_d     = grant_q;
    err_d       = err_q;
    x_d         = x_q;
    y_d         = y_q;
    sym_d       = sym_q;
    col_d       = col_q;
    last_d      = last_q;
    id_d        = id_q;
    wd_d        = wd_q;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          id_d    = win;
          grant_d = 4'b0001 << win;
          ack_d   = 4'b0001 << win;
          x_d     = req_x[8*int'(win) +: 8];
          y_d     = req_y[7*int'(win) +: 7];
          sym_d   = req_sym[2*int'(win) +: 2];
          col_d   = req_col[3*int'(win) +: 3];
          state_d = StGrant;
        end
      end
      StGrant: begin
        eng_start_d = 1'b1;
        state_d     = StStart;
      end
      StStart: begin
        wd_d    = '0;
        state_d = StDraw;
      end
      StDraw: begin
        wd_d = wd_q + 8'd1;
        if (eng_done) begin
          done_d  = grant_q;
          state_d = StDone;
        end else if (wd_q == WdLast) begin
          err_d   = 1'b1;
          done_d  = grant_q;
          state_d = StDone;
        end
      end
      StDone: begin
        last_d  = id_q;
        grant_d = '0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      ack_q       <= '0;
      done_q      <= '0;
      grant_q     <= '0;
      eng_start_q <= 1'b0;
      err_q       <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      sym_q       <= '0;
      col_q       <= '0;
      last_q      <= 2'd3;
      id_q        <= '0;
      wd_q        <= '0;
    end else begin
      state_q     <= state_d;
      ack_q       <= ack_d;
      done_q      <= done_d;
      grant_q     <= grant_d;
      eng_start_q <= eng_start_d;
      err_q       <= err_d;
      x_q         <= x_d;
      y_q         <= y_d;
      sym_q       <= sym_d;
      col_q       <= col_d;
      last_q      <= last_d;
      id_q        <= id_d;
      wd_q        <= wd_d;
    end
  end

  assign ack        = ack_q;
  assign done       = done_q;
  assign grant      = grant_q;
  assign eng_start  = eng_start_q;
  assign eng_x      = x_q;
  assign eng_y      = y_q;
  assign eng_sym    = sym_q;
  assign vga_colour = col_q;
  assign err        = err_q;
  // Pixel strobe passes straight through, but only while the engine owns the port.
  assign vga_plot   = (state_q == StDraw) && eng_plot;

endmodule

// File: tb/tb_symbol_draw_arbiter.sv
// Scoreboard bench: stimulus queues expected ack/done events, a monitor pops and checks them
// as the arbiter pulses, and an engine model drives plot strobes and completion.
module tb_symbol_draw_arbiter;

  typedef struct {
    bit is_done;
    int id;
    int x;
    int y;
    int sym;
    int col;
    int plots;
    bit e;
  } ev_t;

  logic        clk;
  logic        reset_n;
  logic [3:0]  req;
  logic [31:0] req_x;
  logic [27:0] req_y;
  logic [7:0]  req_sym;
  logic [11:0] req_col;
  logic [3:0]  ack, done, grant;
  logic        eng_start;
  logic [7:0]  eng_x;
  logic [6:0]  eng_y;
  logic [1:0]  eng_sym;
  logic [2:0]  vga_colour;
  logic        eng_plot, eng_done, vga_plot, err;

  logic eng_plot_m, eng_done_m, stray_plot, stray_done;
  int   eng_len;
  bit   eng_hang;

  int   total = 0;
  int   bad = 0;
  ev_t  q[$];
  int   plot_cnt;
  bit   start_due;

  assign eng_plot = eng_plot_m | stray_plot;
  assign eng_done = eng_done_m | stray_done;

  symbol_draw_arbiter #(.NUM_REQ(4), .TIMEOUT(127)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req        (req),
    .req_x      (req_x),
    .req_y      (req_y),
    .req_sym    (req_sym),
    .req_col    (req_col),
    .ack        (ack),
    .done       (done),
    .grant      (grant),
    .eng_start  (eng_start),
    .eng_x      (eng_x),
    .eng_y      (eng_y),
    .eng_sym    (eng_sym),
    .vga_colour (vga_colour),
    .eng_plot   (eng_plot),
    .eng_done   (eng_done),
    .vga_plot   (vga_plot),
    .err        (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Engine model: eng_len plot strobes then a done pulse, or plot forever when hung.
  initial begin
    eng_plot_m = 1'b0;
    eng_done_m = 1'b0;
    forever begin
      @(negedge clk);
      if (eng_start === 1'b1) begin
        @(posedge clk); #1;
        if (eng_hang) begin
          eng_plot_m = 1'b1;
          for (int i = 0; i < 400 && done === 4'b0 && reset_n; i++) begin
            @(posedge clk); #1;
          end
          eng_plot_m = 1'b0;
        end else begin
          for (int i = 0; i < eng_len && reset_n; i++) begin
            eng_plot_m = 1'b1;
            @(posedge clk); #1;
          end
          eng_plot_m = 1'b0;
          if (reset_n) begin
            eng_done_m = 1'b1;
            @(posedge clk); #1;
            eng_done_m = 1'b0;
          end
        end
      end
    end
  end

  // Monitor: checks every ack/done pulse against the head of the queue.
  initial begin
    ev_t e;
    plot_cnt  = 0;
    start_due = 1'b0;
    forever begin
      @(negedge clk);
      if (start_due || eng_start) begin
        check("eng_start", 32'(eng_start), 32'(start_due));
        start_due = 1'b0;
      end
      if (vga_plot) plot_cnt++;
      if (ack != 4'b0) begin
        if (q.size() == 0 || q[0].is_done) check("unexpected_ack", 32'(ack), 32'd0);
        else begin
          e = q.pop_front();
          check("ack", 32'(ack), 32'(1) << e.id);
          check("grant_at_ack", 32'(grant), 32'(1) << e.id);
          check("eng_x_at_ack", 32'(eng_x), e.x);
          check("eng_y_at_ack", 32'(eng_y), e.y);
          check("eng_sym_at_ack", 32'(eng_sym), e.sym);
          check("colour_at_ack", 32'(vga_colour), e.col);
          start_due = 1'b1;
          plot_cnt  = 0;
        end
      end
      if (done != 4'b0) begin
        if (q.size() == 0 || !q[0].is_done) check("unexpected_done", 32'(done), 32'd0);
        else begin
          e = q.pop_front();
          check("done", 32'(done), 32'(1) << e.id);
          check("grant_at_done", 32'(grant), 32'(1) << e.id);
          check("eng_x_at_done", 32'(eng_x), e.x);
          check("eng_y_at_done", 32'(eng_y), e.y);
          check("colour_at_done", 32'(vga_colour), e.col);
          check("plot_count", plot_cnt, e.plots);
          check("err_at_done", 32'(err), 32'(e.e));
        end
      end
    end
  end

  task automatic set_fields(input int id, input int x, input int y, input int sym, input int col);
    req_x[8*id +: 8]   = 8'(x);
    req_y[7*id +: 7]   = 7'(y);
    req_sym[2*id +: 2] = 2'(sym);
    req_col[3*id +: 3] = 3'(col);
  endtask

  task automatic expect_draw(input int id, input int x, input int y, input int sym,
                             input int col, input int plots, input bit e, input bit with_done);
    ev_t ev;
    ev.is_done = 1'b0;
    ev.id = id; ev.x = x; ev.y = y; ev.sym = sym; ev.col = col; ev.plots = plots; ev.e = e;
    q.push_back(ev);
    if (with_done) begin
      ev.is_done = 1'b1;
      q.push_back(ev);
    end
  endtask

  task automatic wait_ack(input int id, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (ack[id] !== 1'b1 && cyc < 400);
    if (ack[id] !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL wait_ack%0d: no ack within %0d cycles", id, cyc);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (q.size() != 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL wait_idle: %0d events outstanding", q.size());
      q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    int cyc;
    reset_n    = 1'b1;
    req        = '0;
    req_x      = '0;
    req_y      = '0;
    req_sym    = '0;
    req_col    = '0;
    stray_plot = 1'b0;
    stray_done = 1'b0;
    eng_len    = 0;
    eng_hang   = 1'b0;

    // Reset state
    #2 reset_n = 1'b0;
    #1;
    check("rst_ack", 32'(ack), 0);
    check("rst_done", 32'(done), 0);
    check("rst_grant", 32'(grant), 0);
    check("rst_eng_start", 32'(eng_start), 0);
    check("rst_err", 32'(err), 0);
    check("rst_eng_x", 32'(eng_x), 0);
    check("rst_colour", 32'(vga_colour), 0);
    stray_plot = 1'b1;
    #1 check("rst_vga_plot", 32'(vga_plot), 0);
    stray_plot = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // All four requesting continuously: 0,1,2,3,0
    set_fields(0, 10, 11, 0, 1);
    set_fields(1, 20, 21, 1, 2);
    set_fields(2, 30, 31, 2, 3);
    set_fields(3, 200, 100, 3, 7);
    eng_len = 9;
    expect_draw(0, 10, 11, 0, 1, 9, 1'b0, 1'b1);
    expect_draw(1, 20, 21, 1, 2, 9, 1'b0, 1'b1);
    expect_draw(2, 30, 31, 2, 3, 9, 1'b0, 1'b1);
    expect_draw(3, 200, 100, 3, 7, 9, 1'b0, 1'b1);
    expect_draw(0, 10, 11, 0, 1, 9, 1'b0, 1'b1);
    req = 4'b1111;
    wait_ack(0, cyc);
    wait_ack(1, cyc);
    wait_ack(2, cyc);
    wait_ack(3, cyc);
    wait_ack(0, cyc);
    req = 4'b0000;
    wait_idle();

    // Single request, 51 plot strobes, ack one cycle after sampling
    set_fields(0, 40, 30, 1, 6);
    eng_len = 51;
    expect_draw(0, 40, 30, 1, 6, 51, 1'b0, 1'b1);
    req = 4'b0001;
    wait_ack(0, cyc);
    check("ack_latency", cyc, 1);
    req = 4'b0000;
    wait_idle();

    // Serve 1, then 0110 must go 2 then 1
    eng_len = 4;
    expect_draw(1, 20, 21, 1, 2, 4, 1'b0, 1'b1);
    req = 4'b0010;
    wait_ack(1, cyc);
    req = 4'b0000;
    wait_idle();
    expect_draw(2, 30, 31, 2, 3, 4, 1'b0, 1'b1);
    expect_draw(1, 20, 21, 1, 2, 4, 1'b0, 1'b1);
    req = 4'b0110;
    wait_ack(2, cyc);
    req = 4'b0010;
    wait_ack(1, cyc);
    req = 4'b0000;
    wait_idle();

    // Hung engine: watchdog ends DRAW after 127 cycles and sets err
    eng_hang = 1'b1;
    expect_draw(3, 200, 100, 3, 7, 127, 1'b1, 1'b1);
    req = 4'b1000;
    wait_ack(3, cyc);
    req = 4'b0000;
    wait_idle();
    eng_hang = 1'b0;
    eng_len  = 5;
    expect_draw(0, 40, 30, 1, 6, 5, 1'b1, 1'b1);
    req = 4'b0001;
    wait_ack(0, cyc);
    req = 4'b0000;
    wait_idle();

    // req_x changes mid-draw; latched eng_x must hold
    eng_len = 20;
    expect_draw(0, 40, 30, 1, 6, 20, 1'b1, 1'b1);
    req = 4'b0001;
    wait_ack(0, cyc);
    req = 4'b0000;
    repeat (5) @(negedge clk);
    req_x[7:0] = 8'd90;
    check("eng_x_mid_draw", 32'(eng_x), 40);
    wait_idle();

    // Stray strobes in IDLE are ignored
    stray_plot = 1'b1;
    stray_done = 1'b1;
    #1 check("idle_vga_plot", 32'(vga_plot), 0);
    @(negedge clk);
    stray_plot = 1'b0;
    stray_done = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_done", 32'(done), 0);
    check("idle_grant", 32'(grant), 0);

    // Reset mid-draw aborts without a done pulse and restores priority to requester 0
    set_fields(2, 77, 55, 2, 5);
    eng_len = 40;
    expect_draw(2, 77, 55, 2, 5, 0, 1'b0, 1'b0);
    req = 4'b0100;
    wait_ack(2, cyc);
    req = 4'b0000;
    repeat (5) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("abort_grant", 32'(grant), 0);
    check("abort_ack", 32'(ack), 0);
    check("abort_done", 32'(done), 0);
    check("abort_eng_start", 32'(eng_start), 0);
    check("abort_vga_plot", 32'(vga_plot), 0);
    check("abort_err", 32'(err), 0);
    check("abort_eng_x", 32'(eng_x), 0);
    check("abort_eng_y", 32'(eng_y), 0);
    check("abort_eng_sym", 32'(eng_sym), 0);
    check("abort_colour", 32'(vga_colour), 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    set_fields(0, 1, 2, 3, 4);
    eng_len = 3;
    expect_draw(0, 1, 2, 3, 4, 3, 1'b0, 1'b1);
    expect_draw(2, 77, 55, 2, 5, 3, 1'b0, 1'b1);
    req = 4'b0101;
    wait_ack(0, cyc);
    req = 4'b0100;
    wait_ack(2, cyc);
    req = 4'b0000;
    wait_idle();
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
